relay_link_arbiter: RTL and testbench

Half-duplex direction controller for the relay link in the HF simulate path. Decides which side owns the single relay wire: the remote end (decoded frames arriving, which are replayed locally as modulation) or the local field (raw activity forwarded to the encoder). It drives `mod_type` and the encoder gate, and enforces turnaround guard time and frame timeouts. It sits between the relay decoder/encoder pair and the `hi_simulate` mode register.

---
 rtl/relay_link_arbiter_pkg.sv | 41 ++++
 rtl/relay_link_arbiter_bit_tick.sv | 24 ++
 rtl/relay_link_arbiter.sv | 135 +++++++++++++
 tb/tb_relay_link_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/relay_link_arbiter_pkg.sv
// Shared definitions for the relay link: hi_simulate mode codes, link_state
// encodings and the listen/modulate mod_type pair for each relay mode.
package relay_link_arbiter_pkg;

  localparam logic [2:0] MODE_SNIFFER     = 3'b000;
  localparam logic [2:0] MODE_FAKE_READER = 3'b101;
  localparam logic [2:0] MODE_FAKE_TAG    = 3'b110;

  localparam logic [2:0] READER_LISTEN = 3'b011;
  localparam logic [2:0] READER_MOD    = 3'b100;
  localparam logic [2:0] TAG_LISTEN    = 3'b001;
  localparam logic [2:0] TAG_MOD       = 3'b010;

  typedef enum logic [1:0] {
    LINK_IDLE  = 2'b00,
    LINK_RX    = 2'b01,
    LINK_TX    = 2'b10,
    LINK_GUARD = 2'b11
  } link_state_t;

  function automatic logic mode_enabled(input logic [2:0] mode);
    return (mode == MODE_FAKE_READER) || (mode == MODE_FAKE_TAG);
  endfunction

  function automatic logic [2:0] listen_code(input logic [2:0] mode);
    case (mode)
      MODE_FAKE_READER: return READER_LISTEN;
      MODE_FAKE_TAG:    return TAG_LISTEN;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] mod_code(input logic [2:0] mode);
    case (mode)
      MODE_FAKE_READER: return READER_MOD;
      MODE_FAKE_TAG:    return TAG_MOD;
      default:          return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/relay_link_arbiter_bit_tick.sv
// Free-running relay bit divider: one-cycle tick every BIT_DIV clocks, first
// tick BIT_DIV-1 cycles after reset. Only reset restarts it.
module relay_link_arbiter_bit_tick #(
  parameter int BIT_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  logic [DW-1:0] div;

  // BIT_DIV is a power of two, so the natural wrap closes the period
  always_ff @(posedge clk) begin
    if (reset) div <= '0;
    else       div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/relay_link_arbiter.sv
// Half-duplex owner of the relay wire: chooses remote replay (RX) or local
// forwarding (TX), with idle guard, turnaround dead time and frame timeouts.
module relay_link_arbiter
  import relay_link_arbiter_pkg::*;
#(
  parameter int BIT_DIV            = 16,
  parameter int GUARD_BITS         = 8,
  parameter int TURNAROUND_BITS    = 4,
  parameter int FRAME_TIMEOUT_BITS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hi_simulate_mod_type,
  input  logic       rx_sof,
  input  logic       rx_eof,
  input  logic       local_activity,
  output logic [2:0] mod_type,
  output logic       tx_enable,
  output logic [1:0] link_state,
  output logic       timeout_err,
  output logic       collision_err,
  output logic [7:0] frame_count
);

  localparam int CW = $clog2(FRAME_TIMEOUT_BITS) + 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(FRAME_TIMEOUT_BITS - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_BITS - 1);
  localparam logic [CW-1:0] TURN_LAST    = CW'(TURNAROUND_BITS - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  link_state_t   state, state_nxt;
  logic [2:0]    mode_prev;
  logic [CW-1:0] tick_cnt, idle_cnt;
  logic          fresh;
  logic          tick, tick_cnt_en;
  logic          mode_change, enabled;
  logic          frame_done, timeout_hit, collision;

  relay_link_arbiter_bit_tick #(.BIT_DIV(BIT_DIV)) u_bit_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign mode_change = (hi_simulate_mod_type != mode_prev);
  assign enabled     = mode_enabled(hi_simulate_mod_type);
  // a tick landing in the first cycle of a state does not count toward it
  assign tick_cnt_en = tick && !fresh;

  always_comb begin
    state_nxt   = state;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    collision   = 1'b0;
    if (mode_change || !enabled) begin
      state_nxt = LINK_IDLE;
    end else begin
      case (state)
        LINK_IDLE: begin
          if (rx_sof)              state_nxt = LINK_RX;
          else if (local_activity) state_nxt = LINK_TX;
        end
        LINK_RX: begin
          if (rx_eof) begin
            state_nxt  = LINK_GUARD;
            frame_done = 1'b1;
          end else if (tick_cnt_en && tick_cnt == TIMEOUT_LAST) begin
            state_nxt   = LINK_GUARD;
            timeout_hit = 1'b1;
          end
        end
        LINK_TX: begin
          collision = rx_sof;
          if (tick_cnt_en && tick_cnt == TIMEOUT_LAST) begin
            state_nxt   = LINK_GUARD;
            timeout_hit = 1'b1;
          end else if (tick_cnt_en && !local_activity && idle_cnt == GUARD_LAST) begin
            state_nxt = LINK_GUARD;
          end
        end
        LINK_GUARD: begin
          if (rx_sof)                                      state_nxt = LINK_RX;
          else if (tick_cnt_en && tick_cnt == TURN_LAST)   state_nxt = LINK_IDLE;
        end
        default: state_nxt = LINK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mode_prev <= hi_simulate_mod_type;
    if (reset) begin
      state         <= LINK_IDLE;
      tick_cnt      <= '0;
      idle_cnt      <= '0;
      fresh         <= 1'b1;
      mod_type      <= 3'b000;
      tx_enable     <= 1'b0;
      timeout_err   <= 1'b0;
      collision_err <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      state     <= state_nxt;
      mod_type  <= (state_nxt == LINK_RX) ? mod_code(hi_simulate_mod_type)
                                          : listen_code(hi_simulate_mod_type);
      tx_enable <= (state_nxt == LINK_TX);
      if ((state_nxt != state) || mode_change) begin
        tick_cnt <= '0;
        idle_cnt <= '0;
        fresh    <= 1'b1;
      end else begin
        fresh <= 1'b0;
        if (tick_cnt_en) begin
          tick_cnt <= sat_inc(tick_cnt);
          idle_cnt <= local_activity ? '0 : sat_inc(idle_cnt);
        end
      end
      if (mode_change) begin
        frame_count   <= 8'd0;
        timeout_err   <= 1'b0;
        collision_err <= 1'b0;
      end else begin
        if (frame_done)  frame_count   <= frame_count + 1'b1;
        if (timeout_hit) timeout_err   <= 1'b1;
        if (collision)   collision_err <= 1'b1;
      end
    end
  end

  assign link_state = state;

endmodule

// File: tb/tb_relay_link_arbiter.sv
// Directed bench for relay_link_arbiter: timed vector table plus frame-count
// wrap and reset-mid-frame sequences.
module tb_relay_link_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] hi_simulate_mod_type;
  logic       rx_sof, rx_eof, local_activity;
  logic [2:0] mod_type;
  logic       tx_enable;
  logic [1:0] link_state;
  logic       timeout_err, collision_err;
  logic [7:0] frame_count;

  relay_link_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .hi_simulate_mod_type (hi_simulate_mod_type),
    .rx_sof               (rx_sof),
    .rx_eof               (rx_eof),
    .local_activity       (local_activity),
    .mod_type             (mod_type),
    .tx_enable            (tx_enable),
    .link_state           (link_state),
    .timeout_err          (timeout_err),
    .collision_err        (collision_err),
    .frame_count          (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [2:0] mode;
    logic       sof, eof, act;
    logic [1:0] link;
    logic [2:0] mtype;
    logic       tx;
    logic [7:0] fc;
    logic       ce, te;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  localparam logic [2:0] RD = 3'b101, TG = 3'b110, OFF = 3'b000;
  localparam logic [1:0] S_I = 2'b00, S_R = 2'b01, S_T = 2'b10, S_G = 2'b11;

  task automatic v(input int c, input logic [2:0] m, input logic s, input logic e,
                   input logic a, input logic [1:0] l, input logic [2:0] mt,
                   input logic tx, input logic [7:0] fc, input logic ce, input logic te);
    vec_t r;
    r.cyc = c; r.mode = m; r.sof = s; r.eof = e; r.act = a;
    r.link = l; r.mtype = mt; r.tx = tx; r.fc = fc; r.ce = ce; r.te = te;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, c, got, want);
    end
  endtask

  task automatic chk_all(input int c, input logic [1:0] l, input logic [2:0] mt, input logic tx,
                         input logic [7:0] fc, input logic ce, input logic te);
    chk("link_state",    c, {6'd0, link_state},    {6'd0, l});
    chk("mod_type",      c, {5'd0, mod_type},      {5'd0, mt});
    chk("tx_enable",     c, {7'd0, tx_enable},     {7'd0, tx});
    chk("frame_count",   c, frame_count,           fc);
    chk("collision_err", c, {7'd0, collision_err}, {7'd0, ce});
    chk("timeout_err",   c, {7'd0, timeout_err},   {7'd0, te});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rx_sof = 1'b0;
    rx_eof = 1'b0;
  endtask

  task automatic goto(input int c);
    if (c < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL schedule: vector cycle %0d already passed (now %0d)", c, cyc);
    end
    while (cyc < c) step();
  endtask

  initial begin
    // cycle, mode, sof, eof, act | link, mod_type, tx, frames, coll, tmo
    v(  100, RD, 1, 0, 0, S_I, 3'b011, 0, 0, 0, 0);
    v(  101, RD, 0, 0, 0, S_R, 3'b100, 0, 0, 0, 0);
    v(  600, RD, 0, 1, 0, S_R, 3'b100, 0, 0, 0, 0);
    v(  601, RD, 0, 0, 0, S_G, 3'b011, 0, 1, 0, 0);
    v(  655, RD, 0, 0, 0, S_G, 3'b011, 0, 1, 0, 0);
    v(  656, RD, 0, 0, 0, S_I, 3'b011, 0, 1, 0, 0);
    v(  700, TG, 0, 0, 0, S_I, 3'b011, 0, 1, 0, 0);
    v(  701, TG, 0, 0, 0, S_I, 3'b001, 0, 0, 0, 0);
    v(  720, TG, 0, 0, 1, S_I, 3'b001, 0, 0, 0, 0);
    v(  721, TG, 0, 0, 1, S_T, 3'b001, 1, 0, 0, 0);
    v( 1359, TG, 0, 0, 1, S_T, 3'b001, 1, 0, 0, 0);
    v( 1360, TG, 0, 0, 0, S_T, 3'b001, 1, 0, 0, 0);
    v( 1487, TG, 0, 0, 0, S_T, 3'b001, 1, 0, 0, 0);
    v( 1488, TG, 0, 0, 0, S_G, 3'b001, 0, 0, 0, 0);
    v( 1551, TG, 0, 0, 0, S_G, 3'b001, 0, 0, 0, 0);
    v( 1552, TG, 0, 0, 0, S_I, 3'b001, 0, 0, 0, 0);
    v( 1560, TG, 1, 0, 1, S_I, 3'b001, 0, 0, 0, 0);
    v( 1561, TG, 0, 0, 0, S_R, 3'b010, 0, 0, 0, 0);
    v( 1570, TG, 0, 1, 0, S_R, 3'b010, 0, 0, 0, 0);
    v( 1571, TG, 0, 0, 0, S_G, 3'b001, 0, 1, 0, 0);
    v( 1631, TG, 0, 0, 0, S_G, 3'b001, 0, 1, 0, 0);
    v( 1632, TG, 0, 0, 0, S_I, 3'b001, 0, 1, 0, 0);
    v( 1640, TG, 0, 0, 1, S_I, 3'b001, 0, 1, 0, 0);
    v( 1641, TG, 0, 0, 1, S_T, 3'b001, 1, 1, 0, 0);
    v( 1650, TG, 1, 0, 1, S_T, 3'b001, 1, 1, 0, 0);
    v( 1651, TG, 0, 0, 1, S_T, 3'b001, 1, 1, 1, 0);
    v( 1652, TG, 0, 0, 0, S_T, 3'b001, 1, 1, 1, 0);
    v( 1775, TG, 0, 0, 0, S_T, 3'b001, 1, 1, 1, 0);
    v( 1776, TG, 0, 0, 0, S_G, 3'b001, 0, 1, 1, 0);
    v( 1780, TG, 1, 0, 0, S_G, 3'b001, 0, 1, 1, 0);
    v( 1781, TG, 0, 0, 0, S_R, 3'b010, 0, 1, 1, 0);
    v(18159, TG, 0, 0, 0, S_R, 3'b010, 0, 1, 1, 0);
    v(18160, TG, 0, 0, 0, S_G, 3'b001, 0, 1, 1, 1);
    v(18224, TG, 0, 0, 0, S_I, 3'b001, 0, 1, 1, 1);
    v(18230, RD, 0, 0, 0, S_I, 3'b001, 0, 1, 1, 1);
    v(18231, RD, 0, 0, 0, S_I, 3'b011, 0, 0, 0, 0);
    v(18240, RD, 1, 0, 0, S_I, 3'b011, 0, 0, 0, 0);
    v(18241, RD, 0, 0, 0, S_R, 3'b100, 0, 0, 0, 0);
    v(18250, RD, 0, 1, 0, S_R, 3'b100, 0, 0, 0, 0);
    v(18251, RD, 0, 0, 0, S_G, 3'b011, 0, 1, 0, 0);
    v(18304, RD, 0, 0, 1, S_I, 3'b011, 0, 1, 0, 0);
    v(18305, RD, 0, 0, 1, S_T, 3'b011, 1, 1, 0, 0);
    v(18306, RD, 1, 0, 1, S_T, 3'b011, 1, 1, 0, 0);
    v(18307, RD, 0, 0, 0, S_T, 3'b011, 1, 1, 1, 0);
    v(18432, RD, 0, 0, 0, S_G, 3'b011, 0, 1, 1, 0);
    v(18496, RD, 0, 0, 0, S_I, 3'b011, 0, 1, 1, 0);
    v(18500, RD, 1, 0, 0, S_I, 3'b011, 0, 1, 1, 0);
    v(18501, RD, 0, 0, 0, S_R, 3'b100, 0, 1, 1, 0);
    v(18510, TG, 0, 0, 0, S_R, 3'b100, 0, 1, 1, 0);
    v(18511, TG, 0, 0, 0, S_I, 3'b001, 0, 0, 0, 0);
    v(18520, OFF,0, 0, 0, S_I, 3'b001, 0, 0, 0, 0);
    v(18521, OFF,0, 0, 0, S_I, 3'b000, 0, 0, 0, 0);
    v(18530, OFF,1, 0, 0, S_I, 3'b000, 0, 0, 0, 0);
    v(18531, OFF,0, 0, 1, S_I, 3'b000, 0, 0, 0, 0);
    v(18545, OFF,0, 0, 1, S_I, 3'b000, 0, 0, 0, 0);
    v(18560, TG, 0, 0, 0, S_I, 3'b000, 0, 0, 0, 0);
    v(18561, TG, 0, 0, 0, S_I, 3'b001, 0, 0, 0, 0);

    reset = 1'b1;
    hi_simulate_mod_type = RD;
    rx_sof = 1'b0;
    rx_eof = 1'b0;
    local_activity = 1'b0;
    repeat (3) step();
    chk_all(-1, S_I, 3'b000, 0, 8'd0, 0, 0);
    reset = 1'b0;
    cyc = 0;

    foreach (vecs[i]) begin
      goto(vecs[i].cyc);
      chk_all(cyc, vecs[i].link, vecs[i].mtype, vecs[i].tx, vecs[i].fc, vecs[i].ce, vecs[i].te);
      hi_simulate_mod_type = vecs[i].mode;
      rx_sof               = vecs[i].sof;
      rx_eof               = vecs[i].eof;
      local_activity       = vecs[i].act;
    end

    // back-to-back frames: sof from GUARD re-enters RX at once
    for (int i = 0; i < 256; i++) begin
      rx_sof = 1'b1;
      step();
      rx_eof = 1'b1;
      step();
      if (i == 254) chk("frame_count_255", cyc, frame_count, 8'd255);
    end
    chk("frame_count_wrap", cyc, frame_count, 8'd0);
    chk("link_after_wrap", cyc, {6'd0, link_state}, {6'd0, S_G});

    // reset in the middle of a remote frame
    rx_sof = 1'b1;
    step();
    chk("link_rx_before_reset", cyc, {6'd0, link_state}, {6'd0, S_R});
    reset = 1'b1;
    step();
    chk_all(cyc, S_I, 3'b000, 0, 8'd0, 0, 0);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
